// File: rtl/game_pkg.sv
// Shared shooter-core constants: geometry, bullet tuning, parked coordinates and
// the game/onplay state encodings.
package game_pkg;

   localparam int MAX_PLAYER_BULLET   = 15;
   localparam int PLAYER_BULLET_SPEED = 4;
   localparam int MAX_PLAYER_COOLDOWN = 11;
   localparam int PLAYER_WIDTH        = 24;
   localparam int BULLET_WIDTH        = 4;
   localparam int BULLET_HEIGHT       = 16;
   localparam int NONE_POS_X          = 720;
   localparam int NONE_POS_Y          = 500;
   localparam int SLOT_IDX_W          = 4;

   typedef enum logic [1:0] {
      GAME_IDLE    = 2'd0,
      GAME_PLAYING = 2'd1,
      GAME_OVER    = 2'd2
   } game_state_t;

   typedef enum logic [1:0] {
      ONPLAY_IDLE = 2'd0,
      ONPLAY_MOVE = 2'd1,
      ONPLAY_DRAW = 2'd2
   } onplay_state_t;

   // Bullet spawns BULLET_H above the player's top edge, pinned at the top border.
   function automatic logic [8:0] spawn_y(input logic [8:0] py, input logic [8:0] bh);
      return (py < bh) ? 9'd0 : py - bh;
   endfunction

endpackage

// File: rtl/slot_alloc.sv
// Lowest-index free slot finder: combinational priority encoder over a free mask.
module slot_alloc
   import game_pkg::*;
#(
   parameter int N_SLOT = MAX_PLAYER_BULLET,
   parameter int IW     = SLOT_IDX_W
) (
   input  logic [N_SLOT-1:0] free_mask,
   output logic [IW-1:0]     idx,
   output logic              found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      // Scan high to low so the last hit wins, leaving the lowest index.
      for (int i = N_SLOT - 1; i >= 0; i--) begin
         if (free_mask[i]) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/player_bullet_pool.sv
// Player bullet slot pool: per-frame spawn under cooldown, upward motion,
// top-border retirement, collision kills, and a combinational read port.
module player_bullet_pool
   import game_pkg::*;
#(
   parameter int N_SLOT   = MAX_PLAYER_BULLET,
   parameter int SPEED    = PLAYER_BULLET_SPEED,
   parameter int COOLDOWN = MAX_PLAYER_COOLDOWN,
   parameter int PLAYER_W = PLAYER_WIDTH,
   parameter int BULLET_W = BULLET_WIDTH,
   parameter int BULLET_H = BULLET_HEIGHT,
   parameter int NONE_X   = NONE_POS_X,
   parameter int NONE_Y   = NONE_POS_Y
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              frame_tick,
   input  logic              fire,
   input  logic [9:0]        player_x,
   input  logic [8:0]        player_y,
   input  logic              hit_valid,
   input  logic [3:0]        hit_idx,
   input  logic [3:0]        rd_idx,
   output logic [9:0]        rd_x,
   output logic [8:0]        rd_y,
   output logic [N_SLOT-1:0] active,
   output logic              fired,
   output logic              cooldown_busy
);

   localparam int IW = SLOT_IDX_W;
   localparam int CW = $clog2(COOLDOWN + 1);
   localparam logic [9:0]    NX       = 10'(NONE_X);
   localparam logic [8:0]    NY       = 9'(NONE_Y);
   localparam logic [8:0]    SPD      = 9'(SPEED);
   localparam logic [8:0]    BH       = 9'(BULLET_H);
   localparam logic [9:0]    SPAWN_DX = 10'(PLAYER_W / 2 - BULLET_W / 2);
   localparam logic [CW-1:0] CD_LOAD  = CW'(COOLDOWN);

   logic [N_SLOT-1:0] act_q;
   logic [9:0]        x_q [N_SLOT];
   logic [8:0]        y_q [N_SLOT];
   logic [CW-1:0]     cd_q;
   logic              fired_q;

   logic [N_SLOT-1:0] kill_mask;
   logic [N_SLOT-1:0] free_mask;
   logic [IW-1:0]     alloc_idx;
   logic              alloc_found;
   logic              spawn;
   logic [9:0]        spawn_x_w;
   logic [8:0]        spawn_y_w;

   // A slot being killed this cycle is never handed out, even if it was already idle.
   always_comb begin
      for (int i = 0; i < N_SLOT; i++) begin
         kill_mask[i] = hit_valid && (hit_idx == IW'(i));
         free_mask[i] = !act_q[i] && !kill_mask[i];
      end
   end

   slot_alloc #(.N_SLOT(N_SLOT), .IW(IW)) u_alloc (
      .free_mask (free_mask),
      .idx       (alloc_idx),
      .found     (alloc_found)
   );

   assign spawn     = frame_tick && fire && (cd_q == '0) && alloc_found;
   assign spawn_x_w = player_x + SPAWN_DX;
   assign spawn_y_w = spawn_y(player_y, BH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cd_q    <= '0;
         fired_q <= 1'b0;
         for (int i = 0; i < N_SLOT; i++) begin
            act_q[i] <= 1'b0;
            x_q[i]   <= NX;
            y_q[i]   <= NY;
         end
      end else if (clear) begin
         cd_q    <= '0;
         fired_q <= 1'b0;
         for (int i = 0; i < N_SLOT; i++) begin
            act_q[i] <= 1'b0;
            x_q[i]   <= NX;
            y_q[i]   <= NY;
         end
      end else begin
         fired_q <= spawn;
         if (spawn)
            cd_q <= CD_LOAD;
         else if (frame_tick && cd_q != '0)
            cd_q <= cd_q - CW'(1);
         for (int i = 0; i < N_SLOT; i++) begin
            if (kill_mask[i]) begin
               act_q[i] <= 1'b0;
               x_q[i]   <= NX;
               y_q[i]   <= NY;
            end else if (spawn && alloc_idx == IW'(i)) begin
               act_q[i] <= 1'b1;
               x_q[i]   <= spawn_x_w;
               y_q[i]   <= spawn_y_w;
            end else if (frame_tick && act_q[i]) begin
               // Compare before subtracting so y never wraps past the top border.
               if (y_q[i] < SPD) begin
                  act_q[i] <= 1'b0;
                  x_q[i]   <= NX;
                  y_q[i]   <= NY;
               end else begin
                  y_q[i] <= y_q[i] - SPD;
               end
            end
         end
      end
   end

   always_comb begin
      rd_x = NX;
      rd_y = NY;
      for (int i = 0; i < N_SLOT; i++) begin
         if (rd_idx == IW'(i) && act_q[i]) begin
            rd_x = x_q[i];
            rd_y = y_q[i];
         end
      end
   end

   assign active        = act_q;
   assign fired         = fired_q;
   assign cooldown_busy = (cd_q != '0);

endmodule
